// File: rtl/lfsr_gen.sv
// Fibonacci LFSR: shifts left one step per enabled clock with the XOR of the tapped
// bits entering at bit 0. The raw register is exposed as o_sreg.
module lfsr_gen #(
    parameter logic [31:0] POLY = 32'h0000_D008,
    localparam int SIZE = $clog2(POLY),
    parameter logic [SIZE-1:0] INIT = '1
) (
    input  logic            clock,
    input  logic            i_reset,
    input  logic            i_enable,
    output logic [SIZE-1:0] o_sreg
);

    localparam logic [SIZE-1:0] TAPS = POLY[SIZE-1:0];

    logic [SIZE-1:0] sreg;

    function automatic logic feedback(input logic [SIZE-1:0] s);
        return ^(s & TAPS);
    endfunction

    // An all-zero register would shift zeros forever, so it reloads INIT instead.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            sreg <= INIT;
        end else if (i_enable) begin
            if (sreg == '0) begin
                sreg <= INIT;
            end else begin
                sreg <= {sreg[SIZE-2:0], feedback(sreg)};
            end
        end
    end

    assign o_sreg = sreg;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen with the default 16-bit maximal polynomial.
module tb_lfsr_gen;

    logic        clock;
    logic        i_reset;
    logic        i_enable;
    logic [15:0] o_sreg;

    int vectors;
    int miscompares;

    lfsr_gen dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .o_sreg   (o_sreg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        i_reset  = 1'b0;
        i_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            vectors++;
            if (o_sreg !== 16'hFFFF) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: got %h want ffff", i, o_sreg);
            end
        end
        i_enable = 1'b0;
        i_reset  = 1'b1;
        #1;
        vectors++;
        if (o_sreg !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL reset_release: got %h want ffff", o_sreg);
        end
        @(posedge clock); #1;
        vectors++;
        if (o_sreg !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL reset_first_cycle: got %h want ffff", o_sreg);
        end
    endtask

    task automatic test_sequence();
        logic [15:0] exp_seq [5] = '{16'hFFFE, 16'hFFFC, 16'hFFF8, 16'hFFF0, 16'hFFE1};
        @(negedge clock);
        i_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            vectors++;
            if (o_sreg !== exp_seq[i]) begin
                miscompares++;
                $display("FAIL sequence[%0d]: got %h want %h", i, o_sreg, exp_seq[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [15:0] exp_seq [4] = '{16'hFFC3, 16'hFF87, 16'hFF0F, 16'hFE1E};
        @(negedge clock);
        i_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            vectors++;
            if (o_sreg !== 16'hFFE1) begin
                miscompares++;
                $display("FAIL hold[%0d]: got %h want ffe1", i, o_sreg);
            end
        end
        @(negedge clock);
        i_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            vectors++;
            if (o_sreg !== exp_seq[i]) begin
                miscompares++;
                $display("FAIL resume[%0d]: got %h want %h", i, o_sreg, exp_seq[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        @(posedge clock);
        #3;
        i_reset = 1'b0;
        #1;
        vectors++;
        if (o_sreg !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL async_reset: got %h want ffff", o_sreg);
        end
        @(posedge clock); #1;
        vectors++;
        if (o_sreg !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL async_reset_priority: got %h want ffff", o_sreg);
        end
        @(negedge clock);
        i_reset = 1'b1;
        @(posedge clock); #1;
        vectors++;
        if (o_sreg !== 16'hFFFE) begin
            miscompares++;
            $display("FAIL async_restart: got %h want fffe", o_sreg);
        end
    endtask

    task automatic test_lockup();
        @(negedge clock);
        i_enable = 1'b1;
        force dut.sreg = 16'h0000;
        #1;
        release dut.sreg;
        @(posedge clock); #1;
        vectors++;
        if (o_sreg !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL lockup_recover: got %h want ffff", o_sreg);
        end
    endtask

    task automatic test_period();
        int bad;
        logic [15:0] first_bad;
        bad = 0;
        first_bad = '0;
        @(negedge clock);
        i_reset = 1'b0;
        @(negedge clock);
        i_reset  = 1'b1;
        i_enable = 1'b1;
        for (int i = 1; i < 65535; i++) begin
            @(posedge clock); #1;
            if (o_sreg === 16'hFFFF || o_sreg === 16'h0000 || $isunknown(o_sreg)) begin
                if (bad == 0) first_bad = o_sreg;
                bad++;
            end
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL period_interior: got %0d bad states (first %h) want 0", bad, first_bad);
        end
        @(posedge clock); #1;
        vectors++;
        if (o_sreg !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL period_return: got %h want ffff", o_sreg);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        i_reset     = 1'b0;
        i_enable    = 1'b0;
        test_reset();
        test_sequence();
        test_hold();
        test_async_reset();
        test_lockup();
        test_period();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
